axi4_burst_master: RTL and testbench
====================================

# axi4_burst_master

Single-outstanding AXI4 initiator that turns a simple command/data stream into INCR read or write bursts on the AXI4 master ports, the counterpart of the SRAM slave interface. It sits between a local requester (DMA or CPU-side bridge) and the AXI slave. It handles one transaction at a time: address phase, data beats, then the response. It reports completion status and flags protocol violations seen from the slave.

## Interface
Parameters:
- ID_W, 8, ID width, equal to `AXI_IDS_BITS
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB width = DATA_W/8
- LEN_W, 4, burst length field width; beats = len+1, max 16

Ports:
- ACLK  input  1  clock, all logic on rising edge
- ARESET  input  1  synchronous reset, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_id / cmd_addr / cmd_len  input  ID_W / ADDR_W / LEN_W  transaction ID, start byte address, beats-1
- wd_valid / wd_ready  in / out  1  write data stream handshake
- wd_data / wd_strb  input  DATA_W / DATA_W/8  write beat payload
- rd_valid / rd_ready  out / in  1  read data stream handshake
- rd_data / rd_last  output  DATA_W / 1  read beat payload, last beat marker
- resp_valid  output  1  one-cycle completion pulse
- resp_code  output  2  BRESP, or worst RRESP of the burst
- proto_err  output  1  sticky slave protocol error
- AWID, AWADDR, AWLEN, AWSIZE(3), AWBURST(2), AWVALID  output; AWREADY  input
- WDATA, WSTRB, WLAST, WVALID  output; WREADY  input
- BID, BRESP(2), BVALID  input; BREADY  output
- ARID, ARADDR, ARLEN, ARSIZE(3), ARBURST(2), ARVALID  output; ARREADY  input
- RID, RDATA, RRESP(2), RLAST, RVALID  input; RREADY  output

## Operation
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. On cmd handshake, register id/addr/len, clear beat_cnt and the resp accumulator, then go to AW (write) or AR (read).
- AW/AR: drive registered id/addr/len. Hold VALID=1 with stable payload until READY. Then go to W or R.
- Every burst uses AxSIZE=log2(DATA_W/8) (3'd2 at default) and AxBURST=2'b01 (INCR).
- W: pass-through. WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB=wd_data/wd_strb, WLAST=(beat_cnt==len). beat_cnt increments on each W handshake. The handshake with WLAST=1 moves the FSM to B.
- B: BREADY=1. On BVALID, latch BRESP into resp_code and go to IDLE. If BID != id, set proto_err.
- R: pass-through. rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST. Each handshake increments beat_cnt and sets the accumulator to max(acc, RRESP). The beat at beat_cnt==len moves the FSM to IDLE, with resp_code=max(acc, final RRESP).
- proto_err is set, and never cleared except by reset, on any of: RID != id; RLAST=1 when beat_cnt!=len; RLAST=0 on beat len. The FSM still counts exactly len+1 beats.
- resp_valid is a registered pulse, high for exactly 1 cycle on the cycle after the final B or R handshake.
- Outside their states, all AXI VALID/READY outputs and wd_ready/rd_valid are 0.

## Timing
- Reset: state=IDLE, all VALID/READY outputs 0, cmd_ready=1 on the first cycle after reset, resp_valid=0, resp_code=0, proto_err=0, beat_cnt=0. Address/ID outputs reset to 0.
- Command accepted at edge N: AWVALID or ARVALID is high from cycle N+1.
- Address handshake at edge M: the first WVALID/RREADY is possible in cycle M+1. No beat goes out in the same cycle as AWVALID.
- Final B/R handshake at edge K: resp_valid=1 and cmd_ready=1 in cycle K+1. A new command can be accepted at edge K+1.
- The W and R paths add zero latency, since they are combinational pass-through.
- ARESET asserted mid-burst: the FSM goes to IDLE at that edge and all VALIDs drop the next cycle. The slave transaction is abandoned, with no completion pulse.
- Combinational wd_valid or RVALID with READY low: no beat is counted.

## Test plan
- Write, cmd_len=3, addr 0x100, AWREADY delayed 2 cycles, WREADY always 1 -> AWVALID held 3 cycles with AWLEN=3, AWSIZE=2, AWBURST=1. 4 W beats, WLAST on the 4th only. BRESP=0 -> resp_valid one cycle, resp_code=0.
- Read, cmd_len=0, RRESP=2'b10 with RLAST -> 1 rd beat with rd_last=1. resp_code=2, one cycle after the beat.
- Read, cmd_len=2, RRESP sequence 0,3,1 with rd_ready toggling -> 3 beats delivered, resp_code=3, proto_err=0.
- Read, cmd_len=3, RLAST on beat 2 -> proto_err=1 and stays 1. Completion only after beat 4.
- ARESET pulsed during the 2nd W beat of a len=7 write -> WVALID=0 the next cycle, cmd_ready=1, resp_valid never pulses. A new read then completes normally.
- Back-to-back write then read, BVALID returned immediately -> the AR command is accepted on the cycle resp_valid=1, and ARVALID is high the following cycle.

Source files
------------

// File: rtl/axi4_burst_master_if.sv
// Command/data streams and AXI4 master channels of axi4_burst_master.
// master = the burst engine's view, slave = the requester/AXI-slave side.
interface axi4_burst_master_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wd_valid, wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic [STRB_W-1:0] wd_strb;
    logic              rd_valid, rd_ready, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic              resp_valid, proto_err;
    logic [1:0]        resp_code;

    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [LEN_W-1:0]  AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        output cmd_ready,
        input  wd_valid, wd_data, wd_strb,
        output wd_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output resp_valid, resp_code, proto_err,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        input  cmd_ready,
        output wd_valid, wd_data, wd_strb,
        input  wd_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  resp_valid, resp_code, proto_err,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: command -> address phase ->
// pass-through data beats -> response, with sticky slave protocol checking.
module axi4_burst_master #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input logic                  ACLK,
    input logic                  ARESET,
    axi4_burst_master_if.master  bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));
    localparam logic [1:0]  INCR   = 2'b01;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        acc;
    logic              resp_valid_q, proto_err_q;
    logic [1:0]        resp_code_q;

    logic       last_beat, w_hs, r_hs;
    logic [1:0] rresp_max;

    assign last_beat = (beat_cnt == len_q);
    assign w_hs      = (state == W) && bus.wd_valid && bus.WREADY;
    assign r_hs      = (state == R) && bus.RVALID && bus.rd_ready;
    assign rresp_max = (bus.RRESP > acc) ? bus.RRESP : acc;

    // Control FSM; all status outputs and the captured command are registered here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt     <= '0;
            acc          <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
            proto_err_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        id_q     <= bus.cmd_id;
                        addr_q   <= bus.cmd_addr;
                        len_q    <= bus.cmd_len;
                        beat_cnt <= '0;
                        acc      <= 2'b00;
                        state    <= bus.cmd_write ? AW : AR;
                    end
                end
                AW: if (bus.AWREADY) state <= W;
                AR: if (bus.ARREADY) state <= R;
                W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) state <= B;
                    end
                end
                B: begin
                    if (bus.BVALID) begin
                        resp_code_q  <= bus.BRESP;
                        resp_valid_q <= 1'b1;
                        if (bus.BID != id_q) proto_err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                R: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        acc      <= rresp_max;
                        // Wrong ID or misplaced/missing RLAST; beat counting is unaffected.
                        if ((bus.RID != id_q) || (bus.RLAST != last_beat)) proto_err_q <= 1'b1;
                        if (last_beat) begin
                            resp_code_q  <= rresp_max;
                            resp_valid_q <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_code  = resp_code_q;
    assign bus.proto_err  = proto_err_q;

    assign bus.AWID    = id_q;
    assign bus.AWADDR  = addr_q;
    assign bus.AWLEN   = len_q;
    assign bus.AWSIZE  = AXSIZE;
    assign bus.AWBURST = INCR;
    assign bus.AWVALID = (state == AW);

    assign bus.ARID    = id_q;
    assign bus.ARADDR  = addr_q;
    assign bus.ARLEN   = len_q;
    assign bus.ARSIZE  = AXSIZE;
    assign bus.ARBURST = INCR;
    assign bus.ARVALID = (state == AR);

    // Data channels are zero-latency pass-through, gated by the owning state.
    assign bus.WVALID   = (state == W) && bus.wd_valid;
    assign bus.wd_ready = (state == W) && bus.WREADY;
    assign bus.WDATA    = bus.wd_data;
    assign bus.WSTRB    = bus.wd_strb;
    assign bus.WLAST    = (state == W) && last_beat;
    assign bus.BREADY   = (state == B);

    assign bus.rd_valid = (state == R) && bus.RVALID;
    assign bus.RREADY   = (state == R) && bus.rd_ready;
    assign bus.rd_data  = bus.RDATA;
    assign bus.rd_last  = bus.RLAST;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Self-checking bench for axi4_burst_master: the bench plays requester and
// AXI slave, and checks against burst-level expectations (beats, last, worst resp).
module tb_axi4_burst_master;
    localparam int unsigned ID_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4;
    localparam int unsigned PAY_W = ID_W + ADDR_W + LEN_W + 5;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    axi4_burst_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
    axi4_burst_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [1:0]  txn_resp [16];
    logic [35:0] sent_q [$];
    logic [35:0] got_q [$];
    int obs_addr_cycles, obs_addr_lat, obs_early, obs_beats, obs_resp_early;
    int obs_timeout, obs_unstable, obs_cmd_wait, obs_passthru;
    logic [15:0]      obs_last_mask;
    logic [PAY_W-1:0] obs_pay;
    logic             obs_first_resp_valid;
    logic [1:0]       obs_first_resp_code;
    bit               exp_perr;

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Completion code from the burst rules: BRESP for writes, worst RRESP for reads.
    function automatic logic [1:0] exp_resp(input bit wr, input int len);
        logic [1:0] m;
        if (wr) return txn_resp[0];
        m = 2'b00;
        for (int k = 0; k <= len; k++) if (txn_resp[k] > m) m = txn_resp[k];
        return m;
    endfunction

    function automatic int queue_errs();
        int n;
        n = (got_q.size() == sent_q.size()) ? 0 : 1000;
        for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
            if (got_q[k] !== sent_q[k]) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_id = '0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wd_valid = 0; bus.wd_data = '0; bus.wd_strb = '0; bus.rd_ready = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BID = '0; bus.BRESP = '0; bus.BVALID = 0;
        bus.ARREADY = 0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0; bus.RVALID = 0;
    endtask

    // One transaction driven cycle by cycle; returns right after the final handshake sample.
    task automatic do_txn(input bit wr, input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input int aw_delay, input int vld_pct,
                          input int rdy_pct, input int rlast_err, input logic [ID_W-1:0] rsp_id,
                          input int rst_beat);
        int phase, wait_n, beat, ncyc;
        bit first, axv, axr;
        logic [PAY_W-1:0] cur;
        phase = 0; wait_n = 0; beat = 0; ncyc = 0; first = 1;
        obs_addr_cycles = 0; obs_addr_lat = 0; obs_early = 0; obs_beats = 0; obs_resp_early = 0;
        obs_timeout = 0; obs_unstable = 0; obs_cmd_wait = 0; obs_passthru = 0;
        obs_last_mask = '0; obs_pay = '0;
        sent_q.delete(); got_q.delete();
        while (phase < 4) begin
            @(negedge ACLK);
            idle_inputs();
            case (phase)
                0: begin
                    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_id = id;
                    bus.cmd_addr = addr; bus.cmd_len = len;
                end
                1: begin
                    bus.AWREADY = wr && (wait_n >= aw_delay);
                    bus.ARREADY = !wr && (wait_n >= aw_delay);
                    bus.wd_valid = 1; bus.WREADY = 1; bus.RVALID = 1; bus.rd_ready = 1;
                end
                2: begin
                    if (wr) begin
                        bus.wd_valid = chance(vld_pct); bus.WREADY = chance(rdy_pct);
                        bus.wd_data = $urandom; bus.wd_strb = 4'($urandom);
                        if (beat == rst_beat) begin
                            bus.wd_valid = 1; bus.WREADY = 1; ARESET = 1;
                        end
                    end else begin
                        bus.RVALID = chance(vld_pct); bus.rd_ready = chance(rdy_pct);
                        bus.RDATA = $urandom; bus.RRESP = txn_resp[beat]; bus.RID = rsp_id;
                        bus.RLAST = 1'((beat == int'(len)) ^ (beat == rlast_err));
                    end
                end
                default: begin
                    bus.BVALID = chance(vld_pct); bus.BID = rsp_id; bus.BRESP = txn_resp[0];
                end
            endcase
            #1;
            if (first) begin
                obs_first_resp_valid = bus.resp_valid;
                obs_first_resp_code  = bus.resp_code;
            end else if (bus.resp_valid) obs_resp_early++;
            first = 0;
            case (phase)
                0: begin
                    if (bus.AWVALID || bus.ARVALID) obs_early++;
                    if (bus.cmd_ready) phase = 1; else obs_cmd_wait++;
                end
                1: begin
                    if (bus.WVALID || bus.wd_ready || bus.rd_valid || bus.RREADY) obs_early++;
                    axv = wr ? bus.AWVALID : bus.ARVALID;
                    axr = wr ? bus.AWREADY : bus.ARREADY;
                    if (wr ? bus.ARVALID : bus.AWVALID) obs_early++;
                    cur = wr ? {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST}
                             : {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST};
                    if (axv) begin
                        if (obs_addr_cycles == 0) obs_pay = cur;
                        else if (cur !== obs_pay) obs_unstable++;
                        obs_addr_cycles++;
                        if (axr) phase = 2;
                        wait_n++;
                    end else obs_addr_lat++;
                end
                2: begin
                    if (wr) begin
                        if (bus.WVALID !== bus.wd_valid || bus.wd_ready !== bus.WREADY ||
                            {bus.WSTRB, bus.WDATA} !== {bus.wd_strb, bus.wd_data}) obs_passthru++;
                        if (bus.wd_valid && bus.WREADY) begin
                            sent_q.push_back({bus.wd_strb, bus.wd_data});
                            got_q.push_back({bus.WSTRB, bus.WDATA});
                            if (bus.WLAST) obs_last_mask[beat] = 1'b1;
                            beat++; obs_beats++;
                            if (ARESET) phase = 5;
                            else if (beat == int'(len) + 1) phase = 3;
                        end
                    end else begin
                        if (bus.rd_valid !== bus.RVALID || bus.RREADY !== bus.rd_ready ||
                            bus.rd_data !== bus.RDATA) obs_passthru++;
                        if (bus.RVALID && bus.rd_ready) begin
                            sent_q.push_back({4'h0, bus.RDATA});
                            got_q.push_back({4'h0, bus.rd_data});
                            if (bus.rd_last) obs_last_mask[beat] = 1'b1;
                            beat++; obs_beats++;
                            if (beat == int'(len) + 1) phase = 4;
                        end
                    end
                end
                default: if (bus.BVALID && bus.BREADY) phase = 4;
            endcase
            ncyc++;
            if (ncyc > 400) begin
                obs_timeout = 1;
                phase = 6;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        idle_inputs(); ARESET = 1;
        repeat (2) @(negedge ACLK);
        ARESET = 0; bus.wd_valid = 1; bus.WREADY = 1; bus.RVALID = 1; bus.rd_ready = 1;
        #1;
        total++;
        if ({bus.cmd_ready, bus.AWVALID, bus.ARVALID, bus.WVALID, bus.wd_ready, bus.BREADY,
             bus.RREADY, bus.rd_valid, bus.resp_valid, bus.proto_err} !== 10'b10_0000_0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=1000000000", {bus.cmd_ready, bus.AWVALID,
                bus.ARVALID, bus.WVALID, bus.wd_ready, bus.BREADY, bus.RREADY, bus.rd_valid,
                bus.resp_valid, bus.proto_err});
        end
        total++;
        if ({bus.resp_code, bus.AWID, bus.AWADDR, bus.ARID, bus.ARADDR, bus.AWLEN} !== '0) begin
            bad++; $display("FAIL reset_regs got code=%0d awaddr=%0h awid=%0h awlen=%0d exp=0",
                bus.resp_code, bus.AWADDR, bus.AWID, bus.AWLEN);
        end
        exp_perr = 0;
    endtask

    task automatic test_write_basic();
        txn_resp[0] = 2'b00;
        do_txn(1, 8'h5a, 32'h100, 4'd3, 2, 100, 100, -1, 8'h5a, -1);
        total++;
        if (obs_timeout !== 0) begin bad++; $display("FAIL wr_timeout got=1 exp=0"); end
        total++;
        if (obs_addr_cycles !== 3) begin
            bad++; $display("FAIL wr_awvalid_cycles got=%0d exp=3", obs_addr_cycles);
        end
        total++;
        if (obs_pay !== {8'h5a, 32'h100, 4'd3, 3'd2, 2'b01}) begin
            bad++; $display("FAIL wr_aw_payload got=%0h exp=%0h", obs_pay, {8'h5a, 32'h100, 4'd3, 3'd2, 2'b01});
        end
        total++;
        if (obs_beats !== 4 || obs_last_mask !== 16'h0008) begin
            bad++; $display("FAIL wr_beats got=%0d/%0h exp=4/0008", obs_beats, obs_last_mask);
        end
        total++;
        if (queue_errs() !== 0 || obs_passthru !== 0) begin
            bad++; $display("FAIL wr_data got errs=%0d pt=%0d exp=0", queue_errs(), obs_passthru);
        end
        total++;
        if (obs_early + obs_unstable + obs_addr_lat + obs_resp_early !== 0) begin
            bad++; $display("FAIL wr_timing got early=%0d unst=%0d lat=%0d resp=%0d exp=0",
                obs_early, obs_unstable, obs_addr_lat, obs_resp_early);
        end
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.resp_code, bus.cmd_ready, bus.proto_err} !== 5'b1_00_1_0) begin
            bad++; $display("FAIL wr_resp got=%b exp=10010",
                {bus.resp_valid, bus.resp_code, bus.cmd_ready, bus.proto_err});
        end
        @(negedge ACLK); #1;
        total++;
        if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL wr_resp_pulse got=1 exp=0"); end
    endtask

    task automatic test_read_single();
        txn_resp[0] = 2'b10;
        do_txn(0, 8'h11, 32'h2000, 4'd0, 0, 100, 100, -1, 8'h11, -1);
        total++;
        if (obs_timeout !== 0 || obs_beats !== 1 || obs_last_mask !== 16'h0001) begin
            bad++; $display("FAIL rd1_beats got=%0d/%0h to=%0d exp=1/0001", obs_beats, obs_last_mask, obs_timeout);
        end
        total++;
        if (queue_errs() !== 0 || obs_passthru !== 0) begin
            bad++; $display("FAIL rd1_data got errs=%0d pt=%0d exp=0", queue_errs(), obs_passthru);
        end
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.resp_code} !== 3'b1_10) begin
            bad++; $display("FAIL rd1_resp got=%b exp=110", {bus.resp_valid, bus.resp_code});
        end
    endtask

    task automatic test_read_resp_max();
        txn_resp[0] = 2'd0; txn_resp[1] = 2'd3; txn_resp[2] = 2'd1;
        do_txn(0, 8'h22, 32'h40, 4'd2, 1, 70, 50, -1, 8'h22, -1);
        total++;
        if (obs_timeout !== 0 || obs_beats !== 3 || obs_last_mask !== 16'h0004) begin
            bad++; $display("FAIL rdmax_beats got=%0d/%0h exp=3/0004", obs_beats, obs_last_mask);
        end
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.resp_code, bus.proto_err} !== {1'b1, exp_resp(0, 2), 1'b0}) begin
            bad++; $display("FAIL rdmax_resp got=%b exp=1110", {bus.resp_valid, bus.resp_code, bus.proto_err});
        end
    endtask

    task automatic test_proto_err();
        for (int k = 0; k < 4; k++) txn_resp[k] = 2'd0;
        do_txn(0, 8'h33, 32'h80, 4'd3, 0, 100, 100, 1, 8'h33, -1);
        exp_perr = 1;
        total++;
        if (obs_beats !== 4 || obs_resp_early !== 0 || obs_timeout !== 0) begin
            bad++; $display("FAIL perr_beats got=%0d early_resp=%0d exp=4/0", obs_beats, obs_resp_early);
        end
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.proto_err} !== 2'b11) begin
            bad++; $display("FAIL perr_flag got=%b exp=11", {bus.resp_valid, bus.proto_err});
        end
        do_txn(0, 8'h34, 32'h90, 4'd1, 0, 100, 100, -1, 8'h34, -1);
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.proto_err} !== 2'b11) begin
            bad++; $display("FAIL perr_sticky got=%b exp=11", {bus.resp_valid, bus.proto_err});
        end
    endtask

    task automatic test_mid_reset();
        do_txn(1, 8'h44, 32'h300, 4'd7, 0, 100, 100, -1, 8'h44, 1);
        @(negedge ACLK);
        idle_inputs(); ARESET = 0; bus.wd_valid = 1; bus.WREADY = 1; bus.BVALID = 1; bus.BID = 8'h44;
        #1;
        exp_perr = 0;
        total++;
        if ({bus.WVALID, bus.cmd_ready, bus.resp_valid, bus.proto_err} !== 4'b0100) begin
            bad++; $display("FAIL rst_abort got=%b exp=0100",
                {bus.WVALID, bus.cmd_ready, bus.resp_valid, bus.proto_err});
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK); idle_inputs(); #1;
            total++;
            if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_pulse got=1 exp=0"); end
        end
        txn_resp[0] = 2'd1; txn_resp[1] = 2'd0;
        do_txn(0, 8'h45, 32'h400, 4'd1, 1, 100, 100, -1, 8'h45, -1);
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.resp_code, bus.proto_err} !== 4'b1_01_0 || obs_beats !== 2) begin
            bad++; $display("FAIL rst_recover got=%b beats=%0d exp=1010/2",
                {bus.resp_valid, bus.resp_code, bus.proto_err}, obs_beats);
        end
    endtask

    task automatic test_back_to_back();
        txn_resp[0] = 2'd1;
        do_txn(1, 8'h55, 32'h500, 4'd1, 0, 100, 100, -1, 8'h55, -1);
        txn_resp[0] = 2'd0; txn_resp[1] = 2'd2; txn_resp[2] = 2'd0;
        do_txn(0, 8'h56, 32'h600, 4'd2, 0, 100, 100, -1, 8'h56, -1);
        total++;
        if ({obs_first_resp_valid, obs_first_resp_code} !== 3'b1_01 || obs_cmd_wait !== 0) begin
            bad++; $display("FAIL b2b_accept got=%b wait=%0d exp=101/0",
                {obs_first_resp_valid, obs_first_resp_code}, obs_cmd_wait);
        end
        total++;
        if (obs_addr_lat !== 0 || obs_addr_cycles !== 1) begin
            bad++; $display("FAIL b2b_arvalid got lat=%0d cyc=%0d exp=0/1", obs_addr_lat, obs_addr_cycles);
        end
        @(negedge ACLK); idle_inputs(); #1;
        total++;
        if ({bus.resp_valid, bus.resp_code} !== {1'b1, exp_resp(0, 2)}) begin
            bad++; $display("FAIL b2b_resp got=%b exp=110", {bus.resp_valid, bus.resp_code});
        end
    endtask

    task automatic test_random();
        bit wr, inj;
        logic [ID_W-1:0] id;
        logic [31:0] addr;
        logic [3:0] len;
        logic [1:0] er;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom); id = 8'($urandom); addr = $urandom & 32'hFFFF_FFFC; len = 4'($urandom);
            for (int k = 0; k < 16; k++) txn_resp[k] = 2'($urandom);
            inj = ($urandom_range(7) == 0);
            do_txn(wr, id, addr, len, int'($urandom_range(3)), int'($urandom_range(100, 40)),
                   int'($urandom_range(100, 40)), -1, inj ? (id ^ 8'h01) : id, -1);
            exp_perr = exp_perr | inj;
            er = exp_resp(wr, int'(len));
            total++;
            if (obs_timeout !== 0 || obs_beats !== int'(len) + 1 || obs_last_mask !== (16'd1 << len)) begin
                bad++; $display("FAIL rnd_beats t=%0d got=%0d/%0h exp=%0d/%0h", t, obs_beats,
                    obs_last_mask, int'(len) + 1, 16'd1 << len);
            end
            total++;
            if (obs_pay !== {id, addr, len, 3'd2, 2'b01} || queue_errs() !== 0) begin
                bad++; $display("FAIL rnd_payload t=%0d got=%0h errs=%0d exp=%0h", t, obs_pay,
                    queue_errs(), {id, addr, len, 3'd2, 2'b01});
            end
            total++;
            if (obs_early + obs_unstable + obs_addr_lat + obs_resp_early + obs_passthru !== 0) begin
                bad++; $display("FAIL rnd_timing t=%0d got early=%0d unst=%0d lat=%0d resp=%0d pt=%0d exp=0",
                    t, obs_early, obs_unstable, obs_addr_lat, obs_resp_early, obs_passthru);
            end
            @(negedge ACLK); idle_inputs(); #1;
            total++;
            if ({bus.resp_valid, bus.resp_code, bus.cmd_ready, bus.proto_err} !== {1'b1, er, 1'b1, exp_perr}) begin
                bad++; $display("FAIL rnd_resp t=%0d got=%b exp=%b", t,
                    {bus.resp_valid, bus.resp_code, bus.cmd_ready, bus.proto_err}, {1'b1, er, 1'b1, exp_perr});
            end
        end
    endtask

    initial begin
        ARESET = 1;
        idle_inputs();
        test_reset();
        test_write_basic();
        test_read_single();
        test_read_resp_max();
        test_proto_err();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=expired exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
